// File: rtl/downstream_wr_queue_if.sv
// Update-in and RAM-write handshake bundle for downstream_wr_queue.
// master drives updates and ram_ready; slave is the queue itself.
interface downstream_wr_queue_if #(
  parameter int unsigned ID_W  = 5,
  parameter int unsigned AMT_W = 16
);
  logic             in_valid;
  logic [ID_W-1:0]  in_client_id;
  logic [AMT_W-1:0] in_amount;
  logic             in_ready;
  logic             ram_valid;
  logic             ram_ready;
  logic [ID_W-1:0]  ram_wrindex;
  logic [AMT_W-1:0] ram_wdata;
  logic             ram_we;

  modport master (
    output in_valid, in_client_id, in_amount, ram_ready,
    input  in_ready, ram_valid, ram_wrindex, ram_wdata, ram_we
  );

  modport slave (
    input  in_valid, in_client_id, in_amount, ram_ready,
    output in_ready, ram_valid, ram_wrindex, ram_wdata, ram_we
  );
endinterface

// File: rtl/downstream_wr_queue.sv
// Filters unchanged per-client amount updates and queues the rest, in order,
// for the downstream RAM write port (first-word-fall-through output).
module downstream_wr_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ID_W  = 5,
  parameter int unsigned AMT_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  downstream_wr_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [CNT_W-1:0]        drop_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned N_ID  = 1 << ID_W;
  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  logic [ID_W-1:0]  q_id   [DEPTH];
  logic [AMT_W-1:0] q_amt  [DEPTH];
  logic [AMT_W-1:0] shadow [N_ID];
  logic [N_ID-1:0]  shadow_v;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;

  logic accept, hit, push, pop, drop;

  always_comb begin
    bus.in_ready    = rst_n && (count < FULL);
    bus.ram_valid   = (count != '0);
    bus.ram_wrindex = q_id[rd_ptr];
    bus.ram_wdata   = q_amt[rd_ptr];
    accept          = bus.in_valid && bus.in_ready;
    // Filter against the last accepted value, so back-to-back repeats drop.
    hit             = shadow_v[bus.in_client_id] &&
                      (shadow[bus.in_client_id] == bus.in_amount);
    push            = accept && !hit;
    drop            = accept && hit;
    pop             = bus.ram_valid && bus.ram_ready;
    bus.ram_we      = pop;
    fifo_count      = count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      shadow_v   <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr                       <= wr_ptr + 1'b1;
        shadow_v[bus.in_client_id]   <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

  // Payload storage needs no reset: shadow_v and count qualify every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr]               <= bus.in_client_id;
      q_amt[wr_ptr]              <= bus.in_amount;
      shadow[bus.in_client_id]   <= bus.in_amount;
    end
  end
endmodule

// File: tb/tb_downstream_wr_queue.sv
// Randomised and directed bench for downstream_wr_queue with a queue-based
// reference model and a negedge monitor acting as scoreboard.
module tb_downstream_wr_queue;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned ID_W     = 5;
  localparam int unsigned AMT_W    = 16;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DROP_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]       drop_count;

  downstream_wr_queue_if #(.ID_W(ID_W), .AMT_W(AMT_W)) bus();

  downstream_wr_queue #(
    .DEPTH(DEPTH), .ID_W(ID_W), .AMT_W(AMT_W), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fifo_count (fifo_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [AMT_W-1:0] amt;
  } entry_t;

  int          vectors = 0;
  int          errors  = 0;
  entry_t      exp_q[$];
  logic [AMT_W-1:0] last_amt [int];
  int unsigned exp_drops = 0;
  bit          chk_le1 = 1'b0;
  bit          rand_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Scoreboard: compares DUT state with the model, then advances the model
  // by this cycle's handshakes (pop before push, there is no bypass).
  int unsigned mon_n;
  entry_t      mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_amt.delete();
      exp_drops = 0;
      chk("rst_ram_valid", bus.ram_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_drop_count", drop_count, 0);
    end else begin
      mon_n = exp_q.size();
      chk("fifo_count", fifo_count, mon_n);
      chk("ram_valid", bus.ram_valid, mon_n != 0);
      chk("in_ready", bus.in_ready, mon_n < DEPTH);
      chk("ram_we", bus.ram_we, (mon_n != 0) && bus.ram_ready);
      chk("drop_count", drop_count, exp_drops);
      if (chk_le1) chk("count_le1", fifo_count <= 1, 1);
      if (mon_n != 0) begin
        chk("head_wrindex", bus.ram_wrindex, exp_q[0].id);
        chk("head_wdata", bus.ram_wdata, exp_q[0].amt);
        if (bus.ram_ready) mon_e = exp_q.pop_front();
      end
      if (bus.in_valid && mon_n < DEPTH) begin
        if (last_amt.exists(int'(bus.in_client_id)) &&
            last_amt[int'(bus.in_client_id)] == bus.in_amount) begin
          if (exp_drops < DROP_MAX) exp_drops++;
        end else begin
          mon_e.id  = bus.in_client_id;
          mon_e.amt = bus.in_amount;
          exp_q.push_back(mon_e);
          last_amt[int'(bus.in_client_id)] = bus.in_amount;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [ID_W-1:0] id, input logic [AMT_W-1:0] amt);
    int t = 0;
    logic acc;
    bus.in_valid     = 1'b1;
    bus.in_client_id = id;
    bus.in_amount    = amt;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        timeout("send");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bus.ram_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (fifo_count == 0) break;
      t++;
      if (t > 100) begin
        timeout("drain");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.ram_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_client_id = '0;
    bus.in_amount    = '0;
    bus.ram_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // First push shows up one cycle later with no write strobe.
    send(5'd3, 16'd100);
    @(negedge clk);
    chk("t1_ram_valid", bus.ram_valid, 1);
    chk("t1_wrindex", bus.ram_wrindex, 3);
    chk("t1_wdata", bus.ram_wdata, 100);
    chk("t1_fifo_count", fifo_count, 1);
    chk("t1_ram_we", bus.ram_we, 0);
    @(posedge clk);
    #1;

    // Repeated amounts filter; a changed amount queues behind the first.
    send(5'd3, 16'd100);
    send(5'd3, 16'd100);
    send(5'd3, 16'd101);
    @(negedge clk);
    chk("t2_drop_count", drop_count, 2);
    chk("t2_fifo_count", fifo_count, 2);
    @(posedge clk);
    #1;
    drain();

    // Random traffic over a small id/amount space so filtering happens often.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(ID_W'($urandom_range(0, 3)), AMT_W'($urandom_range(0, 3)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.ram_ready = $urandom_range(0, 1) != 0;
        end
      end
    join
    bus.ram_ready = 1'b0;
    drain();

    // Fill to capacity, then free one slot with a single ram_ready pulse.
    for (int i = 0; i < 8; i++) send(ID_W'(i), AMT_W'(16'h8000 + i));
    bus.in_valid     = 1'b1;
    bus.in_client_id = 5'd8;
    bus.in_amount    = 16'h9000;
    @(negedge clk);
    chk("t3_full_in_ready", bus.in_ready, 0);
    chk("t3_full_count", fifo_count, 8);
    @(posedge clk);
    #1 bus.ram_ready = 1'b1;
    @(negedge clk);
    chk("t3_pulse_we", bus.ram_we, 1);
    chk("t3_pulse_id", bus.ram_wrindex, 0);
    chk("t3_pulse_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 bus.ram_ready = 1'b0;
    @(negedge clk);
    chk("t3_slot_in_ready", bus.in_ready, 1);
    chk("t3_slot_count", fifo_count, 7);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_refill_count", fifo_count, 8);
    @(posedge clk);
    #1;
    drain();

    // Continuous streaming: occupancy never exceeds one, pointers wrap.
    bus.ram_ready = 1'b1;
    chk_le1 = 1'b1;
    for (int i = 0; i < 20; i++) send(ID_W'(i), AMT_W'(16'h4000 + i));
    repeat (3) @(posedge clk);
    #1;
    chk_le1 = 1'b0;
    bus.ram_ready = 1'b0;
    @(negedge clk);
    chk("t4_empty", fifo_count, 0);
    @(posedge clk);
    #1;

    // Reset mid-stream drops queued entries and clears the shadow table.
    send(5'd10, 16'd1);
    send(5'd11, 16'd2);
    send(5'd12, 16'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", bus.ram_valid, 0);
    chk("t5_async_count", fifo_count, 0);
    chk("t5_async_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(5'd3, 16'd100);
    @(negedge clk);
    chk("t5_requeue_count", fifo_count, 1);
    chk("t5_requeue_drop", drop_count, 0);
    @(posedge clk);
    #1;
    drain();

    // Saturate the drop counter with a long run of identical updates.
    send(5'd20, 16'h1234);
    drain();
    bus.in_valid     = 1'b1;
    bus.in_client_id = 5'd20;
    bus.in_amount    = 16'h1234;
    repeat (DROP_MAX + 6) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_drop_sat", drop_count, DROP_MAX);
    chk("t6_count", fifo_count, 0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
